alu_pipe: RTL and testbench

Parametrised successor to the team's 8-bit signed ALU. It takes two N-bit signed operands through a valid/ready input handshake and computes one of seven operations: add, subtract, compare, min, max, absolute difference, and multiply. Multiply runs as an iterative multi-cycle operation under a small FSM. The result is held in a registered output stage with its own valid/ready handshake and status flags. The block sits between an operand-issuing controller and a result consumer that may apply backpressure.

---
 rtl/alu_pipe.sv | 176 +++++++++++++++++
 tb/tb_alu_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: N-bit signed ALU with a valid/ready operand port, a registered result stage and
// an iterative shift-add multiplier sequenced by a two-state FSM.
module alu_pipe #(
  parameter int unsigned N   = 8,
  parameter bit          SAT = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     opcode,
  input  logic [N-1:0]   data1,
  input  logic [N-1:0]   data2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] y,
  output logic           zero,
  output logic           neg,
  output logic           ovf,
  output logic           err,
  output logic           busy
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpCmp = 3'b010;
  localparam logic [2:0] OpMin = 3'b011;
  localparam logic [2:0] OpMax = 3'b100;
  localparam logic [2:0] OpAbs = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;

  // Clamp limits expressed at the N+1-bit working width
  localparam logic signed [N:0] SatMax = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] SatMin = {2'b11, {(N-1){1'b0}}};

  typedef enum logic {StIdle, StMul} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   mcand_q;
  logic [N-1:0]     mplier_q;
  logic             msign_q;

  logic             out_valid_q;
  logic [2*N-1:0]   y_q;
  logic             zero_q, neg_q, ovf_q, err_q;

  logic             accept;
  logic signed [N:0] a_ext, b_ext, sum, diff, r;
  logic             lt, gt;
  logic [1:0]       cmp;
  logic [N-1:0]     mn, mx, abs1, abs2;
  logic [N:0]       ad;
  logic [2*N-1:0]   alu_res;
  logic             alu_ovf, alu_err;
  logic [2*N-1:0]   acc_step, product;

  assign in_ready  = ena & (state_q == StIdle) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == StMul);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  // Single-cycle operations and operand conditioning for the multiplier
  always_comb begin
    a_ext   = $signed({data1[N-1], data1});
    b_ext   = $signed({data2[N-1], data2});
    sum     = a_ext + b_ext;
    diff    = a_ext - b_ext;
    lt      = $signed(data1) < $signed(data2);
    gt      = $signed(data1) > $signed(data2);
    cmp     = gt ? 2'd1 : (lt ? 2'd2 : 2'd0);
    mn      = lt ? data1 : data2;
    mx      = gt ? data1 : data2;
    ad      = diff[N] ? -diff : diff;
    // Magnitudes as unsigned N-bit values; -2^(N-1) maps to 2^(N-1) without loss
    abs1    = data1[N-1] ? (~data1 + 1'b1) : data1;
    abs2    = data2[N-1] ? (~data2 + 1'b1) : data2;
    r       = '0;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (opcode)
      OpAdd, OpSub: begin
        r       = (opcode == OpAdd) ? sum : diff;
        alu_ovf = r[N] ^ r[N-1];
        if (SAT && alu_ovf) begin
          r = r[N] ? SatMin : SatMax;
        end
        alu_res = {{(N-1){r[N]}}, r};
      end
      OpCmp:   alu_res = {{(2*N-2){1'b0}}, cmp};
      OpMin:   alu_res = {{N{mn[N-1]}}, mn};
      OpMax:   alu_res = {{N{mx[N-1]}}, mx};
      OpAbs:   alu_res = {{(N-1){1'b0}}, ad};
      OpMul:   alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step; the last step's sum feeds the sign correction directly
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    product  = msign_q ? (~acc_step + 1'b1) : acc_step;
  end

  // FSM, multiplier datapath and registered result stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      msign_q     <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (ena) begin
      // A consume without a new load empties the stage; loads below override this
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (opcode == OpMul) begin
              acc_q    <= '0;
              mcand_q  <= {{N{1'b0}}, abs1};
              mplier_q <= abs2;
              msign_q  <= data1[N-1] ^ data2[N-1];
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              y_q         <= alu_res;
              zero_q      <= (alu_res == '0);
              neg_q       <= alu_res[2*N-1];
              ovf_q       <= alu_ovf;
              err_q       <= alu_err;
              out_valid_q <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_step;
          mcand_q  <= {mcand_q[2*N-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[N-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            cnt_q       <= '0;
            y_q         <= product;
            zero_q      <= (product == '0);
            neg_q       <= product[2*N-1];
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: two instances (SAT=0 and SAT=1) share stimulus; a
// behavioural model predicts each result at issue time and a monitor checks on consume.
module tb_alu_pipe;

  localparam int N = 8;
  localparam longint MaxV = (longint'(1) << (N - 1)) - 1;
  localparam longint MinV = -(longint'(1) << (N - 1));

  typedef struct {
    longint y0;
    longint y1;
    bit     ovf;
    bit     err;
  } exp_t;

  logic clk = 1'b0;
  logic rst, ena, in_valid, out_ready;
  logic [2:0] opcode;
  logic [N-1:0] data1, data2;

  logic in_ready0, out_valid0, zero0, neg0, ovf0, err0, busy0;
  logic in_ready1, out_valid1, zero1, neg1, ovf1, err1, busy1;
  logic [2*N-1:0] y0, y1;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int mode = 0;  // out_ready policy: 0 always ready, 1 stalled, 2 random

  always #5 clk = ~clk;

  alu_pipe #(.N(N), .SAT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready0),
    .opcode(opcode), .data1(data1), .data2(data2), .out_valid(out_valid0),
    .out_ready(out_ready), .y(y0), .zero(zero0), .neg(neg0), .ovf(ovf0), .err(err0),
    .busy(busy0)
  );

  alu_pipe #(.N(N), .SAT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready1),
    .opcode(opcode), .data1(data1), .data2(data2), .out_valid(out_valid1),
    .out_ready(out_ready), .y(y1), .zero(zero1), .neg(neg1), .ovf(ovf1), .err(err1),
    .busy(busy1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic
  function automatic void model(input logic [2:0] op, input int a, input int b, input bit sat,
                                output longint y, output bit o, output bit e);
    longint r;
    o = 1'b0;
    e = 1'b0;
    case (op)
      3'd0: r = longint'(a) + longint'(b);
      3'd1: r = longint'(a) - longint'(b);
      3'd2: r = (a > b) ? 1 : ((a == b) ? 0 : 2);
      3'd3: r = (a < b) ? a : b;
      3'd4: r = (a > b) ? a : b;
      3'd5: r = (a > b) ? longint'(a) - b : longint'(b) - a;
      3'd6: r = longint'(a) * longint'(b);
      default: begin r = 0; e = 1'b1; end
    endcase
    if (op <= 3'd1 && (r > MaxV || r < MinV)) begin
      o = 1'b1;
      if (sat) r = (r > MaxV) ? MaxV : MinV;
    end
    y = r;
  endfunction

  task automatic push_exp(input logic [2:0] op, input int a, input int b);
    exp_t e;
    bit o1, e1;
    model(op, a, b, 1'b0, e.y0, e.ovf, e.err);
    model(op, a, b, 1'b1, e.y1, o1, e1);
    sb.push_back(e);
  endtask

  // Call just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [2:0] op, input int a, input int b, output int waited);
    waited = 0;
    opcode = op;
    data1 = a[N-1:0];
    data2 = b[N-1:0];
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ena && in_ready0) break;
      waited++;
      if (waited > 200) begin
        chk("issue_timeout", longint'(waited), 0);
        break;
      end
    end
    if (waited <= 200) push_exp(op, a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || out_valid0 || busy0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", longint'(n), 0);
    @(posedge clk);
    #1;
  endtask

  // Timed multiply; returns at the negedge where out_valid first shows
  task automatic mul_timed(input int a, input int b, input bit gap,
                           output int lat, output int bcnt, output int rbad);
    int guard = 0;
    lat = 0;
    bcnt = 0;
    rbad = 0;
    opcode = 3'b110;
    data1 = a[N-1:0];
    data2 = b[N-1:0];
    in_valid = 1'b1;
    @(negedge clk);
    chk("mul_ready_at_issue", longint'(in_ready0), 1);
    push_exp(3'b110, a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid0 || guard > 60) break;
      if (busy0) bcnt++;
      if (in_ready0) rbad++;
      @(posedge clk);
      #1;
      lat++;
      guard++;
      if (gap && lat == 2) ena = 1'b0;
      if (gap && lat == 5) ena = 1'b1;
    end
    chk("mul_busy_cleared", longint'(busy0), 0);
  endtask

  // out_ready driver, updated after the main process's drive point
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every consumed result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ena && out_valid0 && out_ready) begin
        chk("out_valid_sat1", longint'(out_valid1), 1);
        if (sb.size() == 0) begin
          chk("unexpected_result", longint'($signed(y0)), -999);
        end else begin
          e = sb.pop_front();
          chk("y_sat0", longint'($signed(y0)), e.y0);
          chk("y_sat1", longint'($signed(y1)), e.y1);
          chk("zero_sat0", longint'(zero0), longint'(e.y0 == 0));
          chk("neg_sat1", longint'(neg1), longint'(e.y1 < 0));
          chk("neg_sat0", longint'(neg0), longint'(e.y0 < 0));
          chk("ovf_sat0", longint'(ovf0), longint'(e.ovf));
          chk("ovf_sat1", longint'(ovf1), longint'(e.ovf));
          chk("err", longint'(err0), longint'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, bcnt, rbad, stalls, n;
    logic [2*N-1:0] snap;
    rst = 1'b1;
    ena = 1'b0;
    in_valid = 1'b0;
    opcode = '0;
    data1 = '0;
    data2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_y", longint'(y0), 0);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_flags", longint'({zero0, neg0, ovf0, err0}), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_ena_low", longint'(in_ready0), 0);
    ena = 1'b1;
    #1;
    chk("in_ready_after_reset", longint'(in_ready0), 1);
    @(posedge clk);
    #1;

    // Directed single-cycle cases
    issue(3'b000, 127, 1, w);
    issue(3'b001, -128, 1, w);
    issue(3'b001, 5, 5, w);
    issue(3'b000, -128, -128, w);
    issue(3'b010, -3, 4, w);
    issue(3'b011, -3, 4, w);
    issue(3'b100, -3, 4, w);
    issue(3'b101, -3, 4, w);
    issue(3'b101, 127, -128, w);
    issue(3'b010, 9, 9, w);
    issue(3'b010, 10, -10, w);
    issue(3'b111, 5, 6, w);
    wait_idle();

    // Multiply latency, busy window and in_ready
    mul_timed(-128, -128, 1'b0, lat, bcnt, rbad);
    chk("mul_latency", longint'(lat), N);
    chk("mul_busy_cycles", longint'(bcnt), N);
    chk("mul_in_ready_low", longint'(rbad), 0);
    chk("mul_y_exact", longint'($signed(y0)), 16384);
    wait_idle();
    issue(3'b110, -7, 9, w);
    issue(3'b110, 0, -128, w);
    wait_idle();

    // ena low for three cycles mid-multiply
    mul_timed(-100, 77, 1'b1, lat, bcnt, rbad);
    chk("mul_ena_latency", longint'(lat), N + 3);
    chk("mul_ena_busy", longint'(bcnt), N + 3);
    wait_idle();

    // Reset during a multiply discards it
    issue(3'b110, -5, 3, w);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_y", longint'(y0), 0);
    chk("rst_async_busy", longint'(busy0), 0);
    chk("rst_async_out_valid", longint'(out_valid0), 0);
    chk("rst_async_flags", longint'({zero0, neg0, ovf0, err0}), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_midrst", longint'(in_ready0), 1);
    n = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (out_valid0 || busy0) n++;
    end
    chk("no_output_after_rst", longint'(n), 0);
    @(posedge clk);
    #1;

    // Backpressure: one result held, producer stalled, then full-rate stream
    mode = 1;
    @(posedge clk);
    #1;
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int op;
          op = $urandom_range(0, 6);
          if (op == 6) op = 7;
          issue(3'(op), $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, w);
          if (i >= 2) stalls += w;
        end
      end
      begin
        @(posedge clk);
        #2;
        snap = y0;
        repeat (5) begin
          @(negedge clk);
          chk("hold_in_ready", longint'(in_ready0), 0);
          chk("hold_out_valid", longint'(out_valid0), 1);
          chk("hold_y_stable", longint'(y0), longint'(snap));
        end
        mode = 0;
      end
    join
    chk("stream_full_rate", longint'(stalls), 0);
    wait_idle();

    // Random mix with random backpressure
    mode = 2;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom_range(0, 255) - 128,
            $urandom_range(0, 255) - 128, w);
    end
    mode = 0;
    wait_idle();
    chk("scoreboard_empty", longint'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
